// File: rtl/nn_pkg.sv
// Shared types for the dense output layer and the downstream select_max block.
// Q8.8 data, 32-bit products, 40-bit accumulator, and the layer sequencer states.
package nn_pkg;

  localparam int DATA_W        = 16;
  localparam int PROD_W        = 32;
  localparam int ACC_W         = 40;
  localparam int FRAC_BITS_DEF = 8;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIAS,
    ST_MAC,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mac_unit.sv
// Multiply-accumulate datapath for one neuron at a time.
// load_bias seeds the accumulator with the bias scaled into product format;
// acc_en adds w_data*act. result is the narrowed (acc + current product) >>> FRAC_BITS,
// valid combinationally in the cycle that adds the final product.
// Build option: OUT_SATURATION_EN clamps the narrowed result to the 16-bit range;
// without it the low 16 bits are kept (two's-complement wrap).
module mac_unit
  import nn_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_bias,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] act,
  output logic [DATA_W-1:0] result
);

  localparam acc_t SAT_MAX = acc_t'(32767);
  localparam acc_t SAT_MIN = -acc_t'(32768);

  data_t w_s;
  data_t a_s;
  prod_t prod;
  acc_t  sum;
  acc_t  shifted;
  acc_t  acc_d;
  acc_t  acc_q;

  // Product, running sum and the scaled-back value used for the output write.
  always_comb begin
    w_s     = data_t'(w_data);
    a_s     = data_t'(act);
    prod    = prod_t'(w_s) * prod_t'(a_s);
    sum     = acc_q + acc_t'(prod);
    shifted = sum >>> FRAC_BITS;
    acc_d   = acc_q;
    if (load_bias) begin
      acc_d = acc_t'(w_s) <<< FRAC_BITS;
    end else if (acc_en) begin
      acc_d = sum;
    end
  end

`ifdef OUT_SATURATION_EN
  // Clamp to the representable Q8.8 range.
  always_comb begin
    if (shifted > SAT_MAX) begin
      result = 16'h7FFF;
    end else if (shifted < SAT_MIN) begin
      result = 16'h8000;
    end else begin
      result = shifted[DATA_W-1:0];
    end
  end
`else
  // Upper bits are intentionally discarded by the wrapping narrow.
  logic unused_hi;
  assign unused_hi = ^shifted[ACC_W-1:DATA_W] ^ ^SAT_MAX ^ ^SAT_MIN;

  // Keep the low 16 bits.
  always_comb begin
    result = shifted[DATA_W-1:0];
  end
`endif

  // Accumulator register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/dense_output_layer.sv
// Fully connected output layer: N_OUT neurons, N_IN Q8.8 inputs each, weights and
// biases fetched from an external ROM with one cycle read latency.
// Build option: OUT_SATURATION_EN (handled inside mac_unit) selects saturating
// instead of wrapping narrowing of each neuron result.
//
// state    | meaning
// ST_IDLE  | waiting for enable; inputs latched on the start edge
// ST_BIAS  | bias address of neuron n on w_addr
// ST_MAC   | N_IN cycles; cycle k drives weight k, consumes data fetched in cycle k-1
// ST_WRITE | last product added, result written to out_data[n]
// ST_DONE  | layer_done high, outputs held; leaves once enable is low
module dense_output_layer
  import nn_pkg::*;
#(
  parameter int N_IN      = 32,
  parameter int N_OUT     = 10,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  localparam int AW       = $clog2(N_OUT * (N_IN + 1))
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DATA_W*N_IN-1:0]  in_data,
  output logic [AW-1:0]           w_addr,
  input  logic [DATA_W-1:0]       w_data,
  output logic [DATA_W*N_OUT-1:0] out_data,
  output logic                    layer_done
);

  // in_data / out_data element i lives at bits [DATA_W*i +: DATA_W].
  localparam int NW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int KW  = $clog2(N_IN + 1);
  localparam int AIW = (N_IN > 1) ? $clog2(N_IN) : 1;

  state_t          state_q, state_d;
  logic [NW-1:0]   n_q, n_d;
  logic [KW-1:0]   k_q, k_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW-1:0]   w_addr_q, w_addr_d;
  logic            done_q, done_d;
  data_t           act_q [N_IN];
  data_t           act_d [N_IN];
  data_t           out_q [N_OUT];
  data_t           out_d [N_OUT];

  logic              mac_load;
  logic              mac_acc;
  logic [AIW-1:0]    act_idx;
  logic [DATA_W-1:0] act_sel;
  logic [DATA_W-1:0] mac_result;

  // Activation paired with the weight arriving this cycle (fetched one cycle ago).
  always_comb begin
    act_idx = AIW'(k_q - KW'(1));
    act_sel = (k_q == '0) ? '0 : act_q[act_idx];
  end

  // Sequencer next-state, counters and ROM address generation.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    k_d      = k_q;
    base_d   = base_q;
    w_addr_d = w_addr_q;
    done_d   = done_q;
    act_d    = act_q;
    out_d    = out_q;
    mac_load = 1'b0;
    mac_acc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d  = ST_BIAS;
          n_d      = '0;
          k_d      = '0;
          base_d   = '0;
          w_addr_d = AW'(N_IN);
          for (int i = 0; i < N_IN; i++) begin
            act_d[i] = data_t'(in_data[DATA_W*i +: DATA_W]);
          end
        end
      end
      ST_BIAS: begin
        state_d  = ST_MAC;
        k_d      = '0;
        w_addr_d = base_q;
      end
      ST_MAC: begin
        if (k_q == '0) begin
          mac_load = 1'b1;
        end else begin
          mac_acc = 1'b1;
        end
        if (k_q == KW'(N_IN - 1)) begin
          state_d = ST_WRITE;
          k_d     = KW'(N_IN);
        end else begin
          k_d      = k_q + KW'(1);
          w_addr_d = base_q + AW'(k_q) + AW'(1);
        end
      end
      ST_WRITE: begin
        mac_acc    = 1'b1;
        out_d[n_q] = data_t'(mac_result);
        if (n_q == NW'(N_OUT - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_BIAS;
          n_d      = n_q + NW'(1);
          base_d   = base_q + AW'(N_IN + 1);
          w_addr_d = base_d + AW'(N_IN);
        end
      end
      ST_DONE: begin
        // layer_done must be seen high for at least one cycle before leaving.
        if (done_q && !enable) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, counter, input latch and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      k_q      <= '0;
      base_q   <= '0;
      w_addr_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        act_q[i] <= '0;
      end
      for (int i = 0; i < N_OUT; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      k_q      <= k_d;
      base_q   <= base_d;
      w_addr_q <= w_addr_d;
      done_q   <= done_d;
      act_q    <= act_d;
      out_q    <= out_d;
    end
  end

  mac_unit #(
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .load_bias (mac_load),
    .acc_en    (mac_acc),
    .w_data    (w_data),
    .act       (act_sel),
    .result    (mac_result)
  );

  // Flatten the result registers onto the output bus.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < N_OUT; i++) begin
      out_data[DATA_W*i +: DATA_W] = out_q[i];
    end
  end

  assign w_addr     = w_addr_q;
  assign layer_done = done_q;

endmodule

// File: tb/tb_dense_output_layer.sv
// Self-checking bench for dense_output_layer with a registered ROM model and an
// arithmetic reference (sum of w*a plus scaled bias, shift, narrow).
// Honours OUT_SATURATION_EN in its reference when the design is built with it.
module tb_dense_output_layer;

  localparam int N_IN  = 32;
  localparam int N_OUT = 10;
  localparam int FRAC  = 8;
  localparam int AW    = $clog2(N_OUT * (N_IN + 1));
  localparam int ROM_N = N_OUT * (N_IN + 1);
  localparam int LAT   = N_OUT * (N_IN + 2) + 1;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  enable = 1'b0;
  logic [16*N_IN-1:0]    in_data = '0;
  logic [AW-1:0]         w_addr;
  logic [15:0]           w_data = '0;
  logic [16*N_OUT-1:0]   out_data;
  logic                  layer_done;

  logic signed [15:0] rom   [ROM_N];
  logic signed [15:0] act_m [N_IN];
  logic signed [15:0] exp_m [N_OUT];

  int total = 0;
  int bad   = 0;

  dense_output_layer #(
    .N_IN      (N_IN),
    .N_OUT     (N_OUT),
    .FRAC_BITS (FRAC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .in_data    (in_data),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .out_data   (out_data),
    .layer_done (layer_done)
  );

  always #5 clk = ~clk;

  // Registered ROM: data appears one cycle after the address.
  always @(posedge clk) w_data <= (int'(w_addr) < ROM_N) ? rom[w_addr] : 16'h0;

  task automatic set_rom(input logic signed [15:0] w, input logic signed [15:0] b);
    for (int n = 0; n < N_OUT; n++)
      for (int k = 0; k <= N_IN; k++)
        rom[n*(N_IN+1)+k] = (k == N_IN) ? b : w;
  endtask

  task automatic set_act(input logic signed [15:0] a);
    for (int k = 0; k < N_IN; k++) act_m[k] = a;
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < N_IN; k++) in_data[16*k +: 16] = act_m[k];
  endtask

  // Reference: out[n] = narrow((bias*2^F + sum w*a) >>> F).
  task automatic model();
    for (int n = 0; n < N_OUT; n++) begin
      longint acc;
      longint sh;
      acc = longint'(rom[n*(N_IN+1)+N_IN]) <<< FRAC;
      for (int k = 0; k < N_IN; k++)
        acc += longint'(rom[n*(N_IN+1)+k]) * longint'(act_m[k]);
      sh = acc >>> FRAC;
`ifdef OUT_SATURATION_EN
      if (sh > 32767) sh = 32767;
      else if (sh < -32768) sh = -32768;
`endif
      exp_m[n] = sh[15:0];
    end
  endtask

  // Start a run and count edges until layer_done; edges = -1 if it never rises.
  task automatic run_layer(input bit hold, input int change_at, output int edges);
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) enable = 1'b0;
    edges = -1;
    for (int c = 1; c <= 2000; c++) begin
      @(posedge clk);
      #1;
      if (c == change_at) in_data = {N_IN{16'($urandom)}} ^ {(16*N_IN/32){$urandom}};
      if (layer_done) begin
        edges = c;
        break;
      end
    end
    if (!hold) repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out got=%h want=0", out_data); end
    total++; if (layer_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", layer_done); end
    total++; if (w_addr !== '0) begin bad++; $display("FAIL reset_waddr got=%0d want=0", w_addr); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_ones();
    int e;
    set_rom(16'sd256, 16'sd0);
    set_act(16'sd256);
    drive_inputs();
    model();
    run_layer(1'b0, 0, e);
    total++; if (e !== LAT) begin bad++; $display("FAIL ones_latency got=%0d want=%0d", e, LAT); end
    for (int n = 0; n < N_OUT; n++) begin
      total++;
      if (out_data[16*n +: 16] !== exp_m[n]) begin
        bad++; $display("FAIL ones_out[%0d] got=%0d want=%0d", n, $signed(out_data[16*n +: 16]), exp_m[n]);
      end
    end
  endtask

  task automatic test_neg_bias();
    int e;
    set_rom(-16'sd256, 16'sd512);
    set_act(16'sd512);
    drive_inputs();
    model();
    run_layer(1'b0, 0, e);
    total++; if (e !== LAT) begin bad++; $display("FAIL negbias_latency got=%0d want=%0d", e, LAT); end
    for (int n = 0; n < N_OUT; n++) begin
      total++;
      if (out_data[16*n +: 16] !== exp_m[n]) begin
        bad++; $display("FAIL negbias_out[%0d] got=%0d want=%0d", n, $signed(out_data[16*n +: 16]), exp_m[n]);
      end
    end
  endtask

  task automatic test_overflow();
    int e;
    set_rom(16'sd32767, 16'sd0);
    set_act(16'sd32767);
    drive_inputs();
    model();
    run_layer(1'b0, 0, e);
    total++; if (e !== LAT) begin bad++; $display("FAIL ovf_latency got=%0d want=%0d", e, LAT); end
    for (int n = 0; n < N_OUT; n++) begin
      total++;
      if (out_data[16*n +: 16] !== exp_m[n]) begin
        bad++; $display("FAIL ovf_out[%0d] got=%0d want=%0d", n, $signed(out_data[16*n +: 16]), exp_m[n]);
      end
    end
  endtask

  task automatic test_random();
    int e;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < ROM_N; i++) rom[i] = 16'($urandom);
      for (int k = 0; k < N_IN; k++) act_m[k] = (r == 0) ? 16'($urandom_range(0, 1023)) - 16'sd512 : 16'($urandom);
      drive_inputs();
      model();
      run_layer(1'b0, 0, e);
      total++; if (e !== LAT) begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", r, e, LAT); end
      for (int n = 0; n < N_OUT; n++) begin
        total++;
        if (out_data[16*n +: 16] !== exp_m[n]) begin
          bad++; $display("FAIL rand%0d_out[%0d] got=%0d want=%0d", r, n, $signed(out_data[16*n +: 16]), exp_m[n]);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    int e;
    set_rom(16'sd256, 16'sd0);
    set_act(16'sd256);
    drive_inputs();
    model();
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    total++; if (out_data !== '0) begin bad++; $display("FAIL midrst_out got=%h want=0", out_data); end
    total++; if (layer_done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", layer_done); end
    total++; if (w_addr !== '0) begin bad++; $display("FAIL midrst_waddr got=%0d want=0", w_addr); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (layer_done !== 1'b0 || w_addr !== '0) begin
      bad++; $display("FAIL midrst_idle got done=%b addr=%0d want done=0 addr=0", layer_done, w_addr);
    end
    run_layer(1'b0, 0, e);
    total++; if (e !== LAT) begin bad++; $display("FAIL rerun_latency got=%0d want=%0d", e, LAT); end
    for (int n = 0; n < N_OUT; n++) begin
      total++;
      if (out_data[16*n +: 16] !== exp_m[n]) begin
        bad++; $display("FAIL rerun_out[%0d] got=%0d want=%0d", n, $signed(out_data[16*n +: 16]), exp_m[n]);
      end
    end
  endtask

  task automatic test_hold_enable();
    int e;
    int low_cnt;
    int diff_cnt;
    for (int i = 0; i < ROM_N; i++) rom[i] = 16'($urandom_range(0, 1023)) - 16'sd512;
    for (int k = 0; k < N_IN; k++) act_m[k] = 16'($urandom_range(0, 4095)) - 16'sd2048;
    drive_inputs();
    model();
    run_layer(1'b1, 50, e);
    total++; if (e !== LAT) begin bad++; $display("FAIL hold_latency got=%0d want=%0d", e, LAT); end
    for (int n = 0; n < N_OUT; n++) begin
      total++;
      if (out_data[16*n +: 16] !== exp_m[n]) begin
        bad++; $display("FAIL hold_out[%0d] got=%0d want=%0d", n, $signed(out_data[16*n +: 16]), exp_m[n]);
      end
    end
    low_cnt = 0;
    diff_cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (layer_done !== 1'b1) low_cnt++;
      for (int n = 0; n < N_OUT; n++) if (out_data[16*n +: 16] !== exp_m[n]) diff_cnt++;
    end
    total++; if (low_cnt != 0) begin bad++; $display("FAIL hold_done_low_cycles got=%0d want=0", low_cnt); end
    total++; if (diff_cnt != 0) begin bad++; $display("FAIL hold_out_changed got=%0d want=0", diff_cnt); end
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (layer_done !== 1'b0) begin bad++; $display("FAIL hold_release_done got=%b want=0", layer_done); end
  endtask

  task automatic test_neuron3();
    int e;
    int best;
    set_rom(16'sd256, 16'sd0);
    for (int k = 0; k < N_IN; k++) rom[3*(N_IN+1)+k] = 16'sd512;
    set_act(16'sd256);
    drive_inputs();
    model();
    run_layer(1'b0, 0, e);
    total++; if (e !== LAT) begin bad++; $display("FAIL n3_latency got=%0d want=%0d", e, LAT); end
    for (int n = 0; n < N_OUT; n++) begin
      total++;
      if (out_data[16*n +: 16] !== exp_m[n]) begin
        bad++; $display("FAIL n3_out[%0d] got=%0d want=%0d", n, $signed(out_data[16*n +: 16]), exp_m[n]);
      end
    end
    best = 0;
    for (int n = 1; n < N_OUT; n++)
      if ($signed(out_data[16*n +: 16]) > $signed(out_data[16*best +: 16])) best = n;
    total++; if (best != 3) begin bad++; $display("FAIL n3_argmax got=%0d want=3", best); end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_neg_bias();
    test_overflow();
    test_random();
    test_reset_midrun();
    test_hold_enable();
    test_neuron3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
